// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer
//   Transmit-side GMII framer. It takes the Ethernet payload (DA through end
//   of data) from the TX buffer, prepends preamble and SFD, zero-pads frames
//   shorter than MIN_FRAME bytes, appends the CRC-32 FCS and enforces the
//   inter-frame gap before the next frame is started.
//
// Ports
//   TXCLK      in   transmit clock, the only clock
//   RESET      in   asynchronous active-high reset
//   S_DATA     in   payload byte
//   S_VALID    in   S_DATA is valid
//   S_LAST     in   final payload byte of the frame
//   S_READY    out  byte accepted on S_VALID & S_READY at a TXCLK edge
//   TXD        out  GMII transmit data (registered)
//   TXEN       out  GMII transmit enable (registered)
//   TXER       out  GMII transmit error (registered)
//   BUSY       out  high in every state except IDLE
//   FRAME_DONE out  one-cycle pulse on the last FCS byte
//   UNDERRUN   out  one-cycle pulse when a frame is aborted
module gmii_tx_framer #(
    parameter int MIN_FRAME  = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic       TXCLK,
    input  logic       RESET,
    input  logic [7:0] S_DATA,
    input  logic       S_VALID,
    input  logic       S_LAST,
    output logic       S_READY,
    output logic [7:0] TXD,
    output logic       TXEN,
    output logic       TXER,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       UNDERRUN
);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

    state_t      state, state_n;
    logic [7:0]  tick, tick_n;        // cycle counter for PRE, FCS and IFG
    logic [10:0] byte_cnt, cnt_n;     // payload + pad bytes, saturating
    logic [10:0] cnt_inc;
    logic [31:0] crc, crc_n;
    logic [31:0] fcs;
    logic [7:0]  txd_n;
    logic        txen_n, txer_n, done_n, under_n;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Ready is a pure decode of the registered state, so there is no
    // combinational path from S_VALID to S_READY.
    assign S_READY = (state == SFD) || (state == DATA);
    assign BUSY    = (state != IDLE);
    assign cnt_inc = (byte_cnt == '1) ? byte_cnt : byte_cnt + 11'd1;
    assign fcs     = ~crc;

    // The output registers are loaded with the value for the state being
    // entered, so each TXD byte appears the cycle after the edge that
    // produced it (e.g. preamble from cycle 1 after S_VALID is seen).
    always_comb begin
        state_n = state;
        tick_n  = tick;
        cnt_n   = byte_cnt;
        crc_n   = crc;
        txd_n   = '0;
        txen_n  = 1'b0;
        txer_n  = 1'b0;
        done_n  = 1'b0;
        under_n = 1'b0;
        case (state)
            IDLE: begin
                if (S_VALID) begin
                    state_n = PRE;
                    tick_n  = '0;
                    cnt_n   = '0;
                    crc_n   = '1;
                    txd_n   = 8'h55;
                    txen_n  = 1'b1;
                end
            end
            PRE: begin
                txen_n = 1'b1;
                tick_n = tick + 8'd1;
                if (tick == 8'd6) begin
                    txd_n   = 8'hD5;
                    state_n = SFD;
                end else begin
                    txd_n = 8'h55;
                end
            end
            SFD, DATA: begin
                txen_n = 1'b1;
                if (S_VALID) begin
                    txd_n   = S_DATA;
                    crc_n   = crc_byte(crc, S_DATA);
                    cnt_n   = cnt_inc;
                    state_n = DATA;
                    if (S_LAST) begin
                        state_n = (cnt_inc < 11'(MIN_FRAME)) ? PAD : FCS;
                        tick_n  = '0;
                    end
                end else begin
                    // Starved while ready: poison the frame and abort.
                    txer_n  = 1'b1;
                    under_n = 1'b1;
                    state_n = IFG;
                    tick_n  = '0;
                end
            end
            PAD: begin
                txen_n = 1'b1;
                crc_n  = crc_byte(crc, 8'h00);
                cnt_n  = cnt_inc;
                if (cnt_inc >= 11'(MIN_FRAME)) begin
                    state_n = FCS;
                    tick_n  = '0;
                end
            end
            FCS: begin
                txen_n = 1'b1;
                tick_n = tick + 8'd1;
                case (tick[1:0])
                    2'd0:    txd_n = fcs[7:0];
                    2'd1:    txd_n = fcs[15:8];
                    2'd2:    txd_n = fcs[23:16];
                    default: txd_n = fcs[31:24];
                endcase
                if (tick == 8'd3) begin
                    done_n  = 1'b1;
                    state_n = IFG;
                    tick_n  = '0;
                end
            end
            IFG: begin
                // The single IDLE cycle that follows completes the gap, so
                // the first IFG cycle (still showing the final byte) is
                // counted here as one of the IFG_CYCLES edges.
                tick_n = tick + 8'd1;
                if (tick == 8'(IFG_CYCLES - 1))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge TXCLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            tick       <= '0;
            byte_cnt   <= '0;
            crc        <= '1;
            TXD        <= '0;
            TXEN       <= 1'b0;
            TXER       <= 1'b0;
            FRAME_DONE <= 1'b0;
            UNDERRUN   <= 1'b0;
        end else begin
            state      <= state_n;
            tick       <= tick_n;
            byte_cnt   <= cnt_n;
            crc        <= crc_n;
            TXD        <= txd_n;
            TXEN       <= txen_n;
            TXER       <= txer_n;
            FRAME_DONE <= done_n;
            UNDERRUN   <= under_n;
        end
    end

endmodule

// File: doc/gmii_tx_framer.md
# gmii_tx_framer

Transmit-side GMII framer: the transmit counterpart of the receive-path MAC filter. It takes a byte stream of Ethernet payload (destination MAC through end of data) from the transmit buffer, and drives GMII TXD/TXEN/TXER. It adds the preamble and SFD, zero-pads short frames, appends the CRC-32 FCS, and enforces the inter-frame gap. It sits between the TX frame buffer and the PHY/SGMII encoder in the TXCLK domain.

## Interface
- MIN_FRAME, 60: minimum payload+pad byte count, excluding FCS.
- IFG_CYCLES, 12: minimum number of TXEN-low cycles between frames.
- TXCLK  in  1  transmit clock (125 MHz or 25 MHz); the only clock.
- RESET  in  1  reset; asynchronous, active-high.
- S_DATA  in  8  payload byte.
- S_VALID  in  1  S_DATA is valid.
- S_LAST  in  1  qualifies the final payload byte of a frame.
- S_READY  out  1  byte accepted when S_VALID & S_READY are high at a TXCLK edge.
- TXD  out  8  GMII transmit data, registered.
- TXEN  out  1  GMII transmit enable, registered.
- TXER  out  1  GMII transmit error, registered.
- BUSY  out  1  high in every state except IDLE.
- FRAME_DONE  out  1  one-cycle pulse on the last FCS byte cycle.
- UNDERRUN  out  1  one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE:
  - S_VALID=1 (no byte consumed) -> PRE.
- PRE:
  - TXD=0x55 for 7 cycles -> SFD.
- SFD:
  - TXD=0xD5 for 1 cycle.
  - S_READY=1 during this cycle, so the first payload byte is pulled in.
  - -> DATA.
- DATA:
  - Each accepted byte appears on TXD the next cycle.
  - S_READY=1 until the S_LAST byte is accepted, then 0.
  - After the S_LAST byte, if byte count < MIN_FRAME -> PAD; else -> FCS.
- PAD:
  - TXD=0x00 until byte count = MIN_FRAME -> FCS.
- FCS:
  - 4 bytes of ~crc, LSB byte first (crc[7:0] first).
  - FRAME_DONE pulses with the 4th byte -> IFG.
- IFG:
  - TXEN=0 for IFG_CYCLES cycles -> IDLE.
  - S_VALID is ignored in IFG.
- Underrun: in DATA, S_READY=1 and S_VALID=0 (before S_LAST):
  - Next output cycle: TXEN=1, TXER=1, TXD=0x00, UNDERRUN pulse.
  - Then -> IFG. No pad, no FCS.
  - Upstream must flush the remainder of that frame itself.
- CRC:
  - CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF.
  - Computed over payload and pad bytes; excludes preamble and SFD.
  - Byte-wide combinational update, registered once per data/pad byte.
- Byte counter: 11 bits, saturates at 2047. No maximum-length enforcement; the upstream block owns that.
- S_LAST is honoured only together with S_VALID & S_READY.

## Timing
- Reset state: IDLE, TXD=0x00, TXEN=0, TXER=0, S_READY=0, BUSY=0, FRAME_DONE=0, UNDERRUN=0, crc=0xFFFFFFFF, counters=0.
- Asserting RESET mid-frame forces all outputs to reset values immediately. The truncated frame is not completed. No pulse is issued.
- Latency:
  - S_VALID first seen high in IDLE at edge 0.
  - TXEN=1, TXD=0x55 from cycle 1; cycles 1-7 preamble; cycle 8 SFD.
  - First payload byte on TXD at cycle 9.
- Minimum frame is 72 TXEN cycles (8 + 60 + 4).
  - Back-to-back frame starts are 72 + IFG_CYCLES apart.
  - With S_VALID held high, the next PRE starts the cycle after IFG ends.
- TXD, TXEN and TXER change only on TXCLK edges.
- TXEN is contiguous from preamble to the last FCS byte (or to the TXER byte on underrun).
- S_READY is a registered state decode with no combinational path from S_VALID.

## Test plan
- Reset then idle, S_VALID=0 -> TXEN=0, TXD=0x00, S_READY=0 indefinitely; BUSY=0.
- 64-byte payload 0x00..0x3F, S_VALID held -> TXD = 7×0x55, 0xD5, 0x00..0x3F, 4 FCS bytes. Receive-side CRC over payload+FCS gives residue 0xDEBB20E3. FRAME_DONE pulses on cycle 76. TXEN=0 for exactly 12 cycles.
- 14-byte payload -> 46 bytes of 0x00 pad, FCS over 60 bytes. TXEN high for 72 cycles. Residue check passes.
- Drop S_VALID after 20 bytes of a 100-byte frame -> the next cycle shows TXER=1, TXEN=1, TXD=0x00 and UNDERRUN=1. TXEN=0 afterwards with no FCS. The next frame starts only after 12 idle cycles.
- Two 60-byte frames back-to-back -> the second preamble begins exactly 12 cycles after the first TXEN falls. Both frames pass the residue check.
- Assert RESET during DATA -> on the same edge TXEN=0, TXER=0, S_READY=0. After release, a new frame starts cleanly with crc reinitialised.
